// File: rtl/alu_trace_capture.sv
// alu_trace_capture: samples alu_out into a first-word-fall-through FIFO read out over valid/ready
module alu_trace_capture #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter bit ON_CHANGE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_rst,
  input  logic                   cap_en,
  input  logic [WIDTH-1:0]       alu_out,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  input  logic                   clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, first_q, first_d;
  logic [7:0]       drop_q, drop_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push_req, full, pop, push, drop;
  assign rd_valid = count_q != '0;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
  // push/pop arbitration; a pop frees the slot a same-cycle push into a full FIFO needs
  always_comb begin
    push_req = cap_en & ~core_rst & (~ON_CHANGE | first_q | (alu_out != last_q));
    full     = count_q == CW'(DEPTH);
    pop      = rd_valid & rd_ready;
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = drop ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
    drop_d   = drop ? (clr_ovf ? 8'd1 : drop_q + {7'd0, drop_q != 8'hff}) : clr_ovf ? 8'd0 : drop_q;
    last_d   = push ? alu_out : last_q;
    first_d  = core_rst ? 1'b1 : push ? 1'b0 : first_q;
  end
  // control state; async reset returns to the first-sample condition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      last_q   <= '0;
      first_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      last_q   <= last_d;
      first_q  <= first_d;
    end
  end
  // sample storage, not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= alu_out;
  end
endmodule
